// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
// FSM state encoding, default bus widths and access-size encoding
// used by the arbiter, its interface and its sub-modules.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t IF_BUSY = 2'd1;
    localparam state_t D_BUSY  = 2'd2;
    localparam state_t IF_DROP = 2'd3;

    // Access-size encoding carried on d_word / m_word.
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between fetch stage, memory stage, arbiter and the memory.
// modport master: arbiter side (drives acks and the m_* request bus).
// modport slave : environment side (requesters and memory).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    // data requester
    logic              d_req;
    logic              d_we;
    logic              d_word;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    // memory port
    logic              m_req;
    logic              m_we;
    logic              m_word;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_ack, if_rdata,
        input  d_req, d_we, d_word, d_addr, d_wdata,
        output d_ack, d_rdata,
        output m_req, m_we, m_word, m_addr, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_ack, if_rdata,
        output d_req, d_we, d_word, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  m_req, m_we, m_word, m_addr, m_wdata,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating starvation counter with synchronous clear (clear wins).
// Latency: count and sat_o update one cycle after inc_i / clr_i.
// Backpressure: none; sat_o tells the arbiter to serve the starved side.
// Ports: clk_i, rst_ni, inc_i (count one grant), clr_i (restart), sat_o (count == LIMIT).
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data; data wins unless fetch is starved.
// Latency: req -> ack minimum 3 cycles (grant, m_req, ack); one IDLE cycle between grants.
// Backpressure: requesters hold req until ack; stall_if_o / stall_mem_o freeze the pipeline meanwhile.
// Ports: clk_i, rst_ni (async, active low), bus (master modport: fetch, data, memory groups),
//        stall_if_o, stall_mem_o, timeout_err_o (sticky until reset).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.master bus,
    output logic               stall_if_o,
    output logic               stall_mem_o,
    output logic               timeout_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              grant_d, grant_if;
    logic              starve_sat;
    logic              ack_pending;

    logic              m_we_q, m_we_d, m_word_q, m_word_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic              err_q, err_d;

    // While an ack is on the wire the requester is still showing the request it
    // just completed, so no grant is made in that cycle.
    assign ack_pending = if_ack_q | d_ack_q;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (grant_d && bus.if_req),
        .clr_i (grant_if || !bus.if_req),
        .sat_o (starve_sat)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack_pending) begin
                    if (bus.d_req && (!starve_sat || !bus.if_req)) begin
                        grant_d = 1'b1;
                        state_d = D_BUSY;
                    end else if (bus.if_req && !bus.if_flush) begin
                        grant_if = 1'b1;
                        state_d  = IF_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                end else if (bus.if_flush) begin
                    state_d = IF_DROP;
                end
            end
            default: begin // D_BUSY, IF_DROP: wait for the memory to finish
                if (bus.m_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Outputs: request latch, acks, read data, timeout watch
    always_comb begin
        m_we_d     = m_we_q;
        m_word_d   = m_word_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        wait_d     = wait_q;
        err_d      = err_q;

        if (grant_d) begin
            m_we_d    = bus.d_we;
            m_word_d  = bus.d_word;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
        end else if (grant_if) begin
            m_we_d    = 1'b0;
            m_word_d  = SIZE_WORD;
            m_addr_d  = bus.if_addr;
            m_wdata_d = '0;
        end

        // A flush coinciding with completion still drops the instruction.
        if_ack_d = (state_q == IF_BUSY) && bus.m_ready && !bus.if_flush;
        d_ack_d  = (state_q == D_BUSY) && bus.m_ready;
        if (if_ack_d) begin
            if_rdata_d = bus.m_rdata;
        end
        if (d_ack_d) begin
            d_rdata_d = m_we_q ? '0 : bus.m_rdata;
        end

        if (state_q == IDLE) begin
            wait_d = '0;
        end else if (!bus.m_ready) begin
            if (wait_q != TW'(TIMEOUT)) begin
                wait_d = wait_q + 1'b1;
            end
            if (wait_q == TW'(TIMEOUT - 1)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_we_q     <= 1'b0;
            m_word_q   <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            m_we_q     <= m_we_d;
            m_word_q   <= m_word_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    assign bus.m_req    = (state_q != IDLE);
    assign bus.m_we     = m_we_q;
    assign bus.m_word   = m_word_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign timeout_err_o = err_q;

    // Stalls are held asserted for fetch (and released for data) while in reset.
    assign stall_mem_o = rst_ni && bus.d_req && !d_ack_q;
    assign stall_if_o  = !rst_ni || (bus.if_req && !if_ack_q) || stall_mem_o;

endmodule
